// File: rtl/mod_148_8_claim_table.sv
// DPLCA TXOP claim table writer: captures foreign activity per TXOP and sweeps/ages the table once per BEACON cycle.
// Optional DPLCA_SOFT_CLAIM_EN enables the intermediate SOFT_CLAIMED level (11->01->00); otherwise aging goes 11->00.
module mod_148_8_claim_table #(
  parameter int AGE_CYCLES = 4
) (
  input  logic         TX_CLK,
  input  logic         plca_reset,
  input  logic         plca_en,
  input  logic         dplca_en,
  input  logic         dplca_aging,
  input  logic [1:0]   rx_cmd,
  input  logic         plca_tx_beacon,
  input  logic [7:0]   curID,
  input  logic         txop_start,
  input  logic         txop_end,
  input  logic         CRS,
  input  logic         TX_EN,
  output logic [511:0] txop_claim_table_unpacked,
  output logic         dplca_txop_table_upd,
  output logic         dplca_new_age,
  output logic [1:0]   dbg_state
);

  // Handshake: none. All inputs are single-clock level/pulse signals sampled on
  // posedge TX_CLK; dplca_txop_table_upd is a one-clock strobe with no back-pressure.

  localparam logic [1:0] UNCL = 2'b00;
  localparam logic [1:0] HARD = 2'b11;
`ifdef DPLCA_SOFT_CLAIM_EN
  localparam logic [1:0] SOFT = 2'b01;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   tbl [256];
  logic [255:0] seen;
  logic [255:0] period;
  logic [7:0]   idx;
  logic [7:0]   age_cnt;
  logic         aging;
  logic         pending;
  logic         busy;
  logic         rx_bcn_q;
  logic         cyc_q;

  logic         rx_bcn;
  logic         cyc_cond;
  logic         cyc_event;
  logic         rx_rise;
  logic         busy_eff;
  logic [255:0] seen_set;
  logic         hit;
  logic [1:0]   cur;
  logic [1:0]   demoted;
  logic [1:0]   new_entry;
  logic [8:0]   age_sum;
  logic         next_aging;
  logic [7:0]   next_age_cnt;
  logic         clear_all;

  assign clear_all = plca_reset | ~plca_en | ~dplca_en;

  assign rx_bcn    = (rx_cmd == 2'b00);
  assign cyc_cond  = rx_bcn | plca_tx_beacon;
  assign cyc_event = cyc_cond & ~cyc_q;
  assign rx_rise   = rx_bcn & ~rx_bcn_q;

  // Only carrier with our own TX_EN low counts as someone else's transmission.
  assign busy_eff  = (busy & ~txop_start) | (CRS & ~TX_EN);

  always_comb begin
    seen_set = '0;
    if (txop_end && busy_eff) seen_set[curID] = 1'b1;
    if (rx_rise)              seen_set[0]     = 1'b1;
  end

  assign hit = seen[idx] | seen_set[idx];
  assign cur = tbl[idx];

`ifdef DPLCA_SOFT_CLAIM_EN
  assign demoted = (cur == HARD) ? SOFT : UNCL;
`else
  assign demoted = UNCL;
`endif

  always_comb begin
    if (hit)                       new_entry = HARD;
    else if (aging && !period[idx]) new_entry = demoted;
    else                           new_entry = cur;
  end

  // Aging decision taken when a sweep is launched; age_cnt is pinned to 0 while aging is disallowed.
  assign age_sum      = {1'b0, age_cnt} + 9'd1;
  assign next_aging   = dplca_aging && (age_sum == 9'(AGE_CYCLES));
  assign next_age_cnt = (!dplca_aging || next_aging) ? 8'd0 : age_sum[7:0];

  always_ff @(posedge TX_CLK) begin
    if (clear_all) begin
      for (int i = 0; i < 256; i++) tbl[i] <= UNCL;
      seen                 <= '0;
      period               <= '0;
      idx                  <= '0;
      age_cnt              <= '0;
      aging                <= 1'b0;
      pending              <= 1'b0;
      busy                 <= 1'b0;
      rx_bcn_q             <= 1'b0;
      cyc_q                <= 1'b0;
      dplca_txop_table_upd <= 1'b0;
      dplca_new_age        <= 1'b0;
      state                <= IDLE;
    end else begin
      rx_bcn_q             <= rx_bcn;
      cyc_q                <= cyc_cond;
      busy                 <= busy_eff;
      dplca_txop_table_upd <= 1'b0;

      // A set arriving for the entry under sweep wins over its clear.
      if (state == SWEEP) seen <= (seen & ~(256'(1) << idx)) | seen_set;
      else                seen <= seen | seen_set;

      case (state)
        IDLE: begin
          if (cyc_event) begin
            state   <= SWEEP;
            idx     <= '0;
            aging   <= next_aging;
            age_cnt <= next_age_cnt;
          end
        end
        SWEEP: begin
          tbl[idx] <= new_entry;
          if (hit)        period[idx] <= 1'b1;
          else if (aging) period[idx] <= 1'b0;
          if (cyc_event) pending <= 1'b1;
          idx <= idx + 8'd1;
          if (idx == 8'd255) begin
            state                <= DONE;
            dplca_txop_table_upd <= 1'b1;
            dplca_new_age        <= aging;
          end
        end
        DONE: begin
          if (pending || cyc_event) begin
            state   <= SWEEP;
            pending <= 1'b0;
            idx     <= '0;
            aging   <= next_aging;
            age_cnt <= next_age_cnt;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 256; g++) begin : g_unpack
    assign txop_claim_table_unpacked[2*g +: 2] = tbl[g];
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mod_148_8_claim_table.sv
// Self-checking bench for mod_148_8_claim_table: randomized TXOP activity against a whole-table sweep model.
module tb_mod_148_8_claim_table;

  localparam int AGE = 4;

  logic         TX_CLK = 1'b0;
  logic         plca_reset = 1'b1;
  logic         plca_en = 1'b1;
  logic         dplca_en = 1'b1;
  logic         dplca_aging = 1'b1;
  logic [1:0]   rx_cmd = 2'b10;
  logic         plca_tx_beacon = 1'b0;
  logic [7:0]   curID = '0;
  logic         txop_start = 1'b0;
  logic         txop_end = 1'b0;
  logic         CRS = 1'b0;
  logic         TX_EN = 1'b0;
  logic [511:0] tbl_out;
  logic         upd;
  logic         new_age;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: {new_age, table} expected after each completed sweep.
  logic [512:0] exp_q[$];

  // Reference model state.
  int m_tbl[256];
  bit m_seen[256];
  bit m_period[256];
  int m_age;

  mod_148_8_claim_table #(.AGE_CYCLES(AGE)) dut (
    .TX_CLK                    (TX_CLK),
    .plca_reset                (plca_reset),
    .plca_en                   (plca_en),
    .dplca_en                  (dplca_en),
    .dplca_aging               (dplca_aging),
    .rx_cmd                    (rx_cmd),
    .plca_tx_beacon            (plca_tx_beacon),
    .curID                     (curID),
    .txop_start                (txop_start),
    .txop_end                  (txop_end),
    .CRS                       (CRS),
    .TX_EN                     (TX_EN),
    .txop_claim_table_unpacked (tbl_out),
    .dplca_txop_table_upd      (upd),
    .dplca_new_age             (new_age),
    .dbg_state                 (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 TX_CLK = ~TX_CLK;

  task automatic tick();
    @(posedge TX_CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_tbl[i] = 0;
      m_seen[i] = 0;
      m_period[i] = 0;
    end
    m_age = 0;
    exp_q.delete();
  endtask

  task automatic reset_all();
    plca_reset = 1'b1;
    tick();
    tick();
    plca_reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [511:0] model_pack();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 256; i++) v[2*i +: 2] = 2'(m_tbl[i]);
    return v;
  endfunction

  // One whole BEACON cycle worth of table update, applied at once.
  task automatic model_sweep();
    bit ag;
    if (dplca_aging) begin
      m_age++;
      ag = (m_age == AGE);
      if (ag) m_age = 0;
    end else begin
      m_age = 0;
      ag = 0;
    end
    for (int i = 0; i < 256; i++) begin
      if (m_seen[i]) begin
        m_tbl[i] = 3;
        m_period[i] = 1;
      end else begin
        if (ag && !m_period[i]) begin
`ifdef DPLCA_SOFT_CLAIM_EN
          m_tbl[i] = (m_tbl[i] == 3) ? 1 : 0;
`else
          m_tbl[i] = 0;
`endif
        end
        if (ag) m_period[i] = 0;
      end
      m_seen[i] = 0;
    end
    exp_q.push_back({ag, model_pack()});
  endtask

  // ---------------- drivers ----------------
  task automatic do_txop(input int id, input bit crs, input bit txen);
    curID = 8'(id);
    txop_start = 1'b1;
    tick();
    txop_start = 1'b0;
    CRS = crs;
    TX_EN = txen;
    tick();
    txop_end = 1'b1;
    tick();
    txop_end = 1'b0;
    CRS = 1'b0;
    TX_EN = 1'b0;
    tick();
    if (crs && !txen) m_seen[id] = 1;
  endtask

  task automatic fire_event(input bit use_rx);
    if (use_rx) rx_cmd = 2'b00;
    else        plca_tx_beacon = 1'b1;
    tick();
    rx_cmd = 2'b10;
    plca_tx_beacon = 1'b0;
    if (use_rx) m_seen[0] = 1;
    model_sweep();
  endtask

  task automatic entry_of(input int i, output logic [1:0] e);
    e = tbl_out[2*i +: 2];
  endtask

  // Waits for the sweep-done strobe, then compares new_age and the table one clock later.
  task automatic check_sweep(input string name);
    int n;
    logic [512:0] e;
    logic [1:0] a;
    n = 0;
    while (upd !== 1'b1 && n < 700) begin
      tick();
      n++;
    end
    vectors++;
    if (upd !== 1'b1) begin
      miscompares++;
      $display("FAIL %s upd_timeout: upd=%b after %0d clocks, required 1", name, upd, n);
      return;
    end
    e = exp_q.pop_front();
    tick();
    vectors++;
    if (new_age !== e[512]) begin
      miscompares++;
      $display("FAIL %s new_age: got %b expected %b", name, new_age, e[512]);
    end
    vectors++;
    if (tbl_out !== e[511:0]) begin
      miscompares++;
      for (int i = 0; i < 256; i++) begin
        entry_of(i, a);
        if (a !== e[2*i +: 2]) begin
          $display("FAIL %s table: first diff entry %0d got %b expected %b", name, i, a, e[2*i +: 2]);
          break;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_all();
    vectors++;
    if (upd !== 1'b0 || new_age !== 1'b0 || dbg_state !== 2'd0 || tbl_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state: upd=%b new_age=%b state=%0d tbl_nonzero=%b, required 0/0/0/0",
               upd, new_age, dbg_state, |tbl_out);
    end
    // disabling DPLCA wipes a populated table
    do_txop(9, 1, 0);
    fire_event(0);
    check_sweep("disable_pre");
    dplca_en = 1'b0;
    tick();
    dplca_en = 1'b1;
    model_reset();
    vectors++;
    if (tbl_out !== '0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL dplca_en_clear: tbl_nonzero=%b state=%0d, required 0/0", |tbl_out, dbg_state);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit saw;
    reset_all();
    do_txop(40, 1, 0);
    fire_event(1);
    for (int i = 0; i < 100; i++) tick();
    plca_reset = 1'b1;
    tick();
    plca_reset = 1'b0;
    model_reset();
    vectors++;
    if (tbl_out !== '0 || upd !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid: tbl_nonzero=%b upd=%b state=%0d, required 0/0/0", |tbl_out, upd, dbg_state);
    end
    saw = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (upd === 1'b1) saw = 1;
    end
    vectors++;
    if (saw) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: upd pulsed=%b, required 0", saw);
    end
  endtask

  task automatic test_claim();
    logic [1:0] a;
    logic [512:0] e;
    bit early;
    reset_all();
    do_txop(5, 1, 0);
    fire_event(1);                       // now in clock k+1
    for (int i = 0; i < 5; i++) tick();  // clock k+6
    entry_of(5, a);
    vectors++;
    if (a !== 2'b00) begin
      miscompares++;
      $display("FAIL claim_k6: entry5=%b expected 00", a);
    end
    tick();                              // clock k+7
    entry_of(5, a);
    vectors++;
    if (a !== 2'b11) begin
      miscompares++;
      $display("FAIL claim_k7: entry5=%b expected 11", a);
    end
    early = 0;
    for (int c = 8; c <= 256; c++) begin
      tick();
      if (upd !== 1'b0) early = 1;
    end
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL claim_upd_early: upd seen before k+257, required none");
    end
    tick();                              // clock k+257
    vectors++;
    if (upd !== 1'b1) begin
      miscompares++;
      $display("FAIL claim_upd_k257: upd=%b expected 1", upd);
    end
    tick();                              // clock k+258
    e = exp_q.pop_front();
    vectors++;
    if (upd !== 1'b0 || new_age !== 1'b0) begin
      miscompares++;
      $display("FAIL claim_after: upd=%b new_age=%b expected 0/0", upd, new_age);
    end
    vectors++;
    if (tbl_out !== e[511:0]) begin
      miscompares++;
      $display("FAIL claim_table: entry0=%b entry5=%b expected %b %b",
               tbl_out[1:0], tbl_out[11:10], e[1:0], e[11:10]);
    end
  endtask

  task automatic test_local_no_claim();
    reset_all();
    do_txop(3, 1, 1);
    fire_event(0);
    check_sweep("local");
    vectors++;
    if (tbl_out[7:6] !== 2'b00 || tbl_out[1:0] !== 2'b00) begin
      miscompares++;
      $display("FAIL local_entries: entry3=%b entry0=%b expected 00 00", tbl_out[7:6], tbl_out[1:0]);
    end
  endtask

  task automatic test_aging();
    logic [1:0] a;
    logic [1:0] want;
    reset_all();
    dplca_aging = 1'b1;
    do_txop(7, 1, 0);
    for (int c = 1; c <= 3 * AGE; c++) begin
      fire_event(0);
      check_sweep("aging");
      if (c % AGE == 0) begin
        entry_of(7, a);
`ifdef DPLCA_SOFT_CLAIM_EN
        want = (c == AGE) ? 2'b11 : (c == 2 * AGE) ? 2'b01 : 2'b00;
`else
        want = (c == AGE) ? 2'b11 : 2'b00;
`endif
        vectors++;
        if (a !== want || new_age !== 1'b1) begin
          miscompares++;
          $display("FAIL aging_period%0d: entry7=%b new_age=%b expected %b 1", c / AGE, a, new_age, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [512:0] e;
    reset_all();
    dplca_aging = 1'b1;
    do_txop(20, 1, 0);
    fire_event(0);
    for (int i = 0; i < 50; i++) tick();
    fire_event(0);
    n = 0;
    while (upd !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (upd !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_timeout: upd=%b required 1", upd);
      return;
    end
    e = exp_q.pop_front();
    tick();
    vectors++;
    if (dbg_state !== 2'd1 || tbl_out !== e[511:0]) begin
      miscompares++;
      $display("FAIL b2b_resweep: state=%0d tbl_ok=%b required state 1 and table match",
               dbg_state, tbl_out === e[511:0]);
    end
    n = 1;
    while (upd !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 257) begin
      miscompares++;
      $display("FAIL b2b_spacing: second upd after %0d clocks, required 257", n);
    end
    e = exp_q.pop_front();
    tick();
    vectors++;
    if (tbl_out !== e[511:0] || new_age !== e[512]) begin
      miscompares++;
      $display("FAIL b2b_second: new_age=%b expected %b tbl_ok=%b", new_age, e[512], tbl_out === e[511:0]);
    end
  endtask

  task automatic test_no_aging();
    reset_all();
    dplca_aging = 1'b0;
    do_txop(11, 1, 0);
    for (int c = 0; c < 10; c++) begin
      fire_event(c % 2 == 0);
      check_sweep("no_aging");
    end
    vectors++;
    if (tbl_out[23:22] !== 2'b11 || new_age !== 1'b0) begin
      miscompares++;
      $display("FAIL no_aging_hold: entry11=%b new_age=%b expected 11 0", tbl_out[23:22], new_age);
    end
    dplca_aging = 1'b1;
  endtask

  task automatic test_random();
    int n;
    reset_all();
    for (int c = 0; c < 12; c++) begin
      dplca_aging = ($urandom_range(0, 4) != 0);
      n = $urandom_range(0, 4);
      for (int t = 0; t < n; t++)
        do_txop($urandom_range(0, 255), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      fire_event(1'($urandom_range(0, 1)));
      check_sweep("random");
    end
    dplca_aging = 1'b1;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    model_reset();
    test_reset();
    test_claim();
    test_local_no_claim();
    test_aging();
    test_back_to_back();
    test_no_aging();
    test_random();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
